// File: rtl/parking_pkg.sv
// Shared definitions for the multi-floor parking controller.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package parking_pkg;

    // PS/2 make codes for the keys the controller reacts to
    localparam logic [7:0] KEY_0   = 8'h45;
    localparam logic [7:0] KEY_1   = 8'h16;
    localparam logic [7:0] KEY_2   = 8'h1E;
    localparam logic [7:0] KEY_3   = 8'h26;
    localparam logic [7:0] KEY_4   = 8'h25;
    localparam logic [7:0] KEY_5   = 8'h2E;
    localparam logic [7:0] KEY_6   = 8'h36;
    localparam logic [7:0] KEY_7   = 8'h3D;
    localparam logic [7:0] KEY_8   = 8'h3E;
    localparam logic [7:0] KEY_9   = 8'h46;
    localparam logic [7:0] KEY_ESC = 8'h76;

    // Segment patterns, bit order g..a, active-low
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_FLR = 3'd1,
        ST_GET_PIN = 3'd2,
        ST_CHECK   = 3'd3,
        ST_ACCEPT  = 3'd4,
        ST_REJECT  = 3'd5
    } state_t;

    // Returns {valid, digit}; valid=0 for any non-digit code
    function automatic logic [4:0] scan_to_digit(input logic [7:0] code);
        case (code)
            KEY_0:   scan_to_digit = {1'b1, 4'd0};
            KEY_1:   scan_to_digit = {1'b1, 4'd1};
            KEY_2:   scan_to_digit = {1'b1, 4'd2};
            KEY_3:   scan_to_digit = {1'b1, 4'd3};
            KEY_4:   scan_to_digit = {1'b1, 4'd4};
            KEY_5:   scan_to_digit = {1'b1, 4'd5};
            KEY_6:   scan_to_digit = {1'b1, 4'd6};
            KEY_7:   scan_to_digit = {1'b1, 4'd7};
            KEY_8:   scan_to_digit = {1'b1, 4'd8};
            KEY_9:   scan_to_digit = {1'b1, 4'd9};
            default: scan_to_digit = {1'b0, 4'd0};
        endcase
    endfunction

    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_to_seg = 7'h40;
            4'd1:    digit_to_seg = 7'h79;
            4'd2:    digit_to_seg = 7'h24;
            4'd3:    digit_to_seg = 7'h30;
            4'd4:    digit_to_seg = 7'h19;
            4'd5:    digit_to_seg = 7'h12;
            4'd6:    digit_to_seg = 7'h02;
            4'd7:    digit_to_seg = 7'h78;
            4'd8:    digit_to_seg = 7'h00;
            4'd9:    digit_to_seg = 7'h10;
            default: digit_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd7seg_2dig.sv
// Binary 0..99 to two registered 7-segment digits (tens, units), with blanking.
// Latency: 1 cycle from value/blank to segment outputs.
// Backpressure: none, free-running. Ports: clk, rst_n, value[6:0], blank -> seg_left, seg_right.
module bcd7seg_2dig
    import parking_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] value,
    input  logic       blank,
    output logic [6:0] seg_left,
    output logic [6:0] seg_right
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_left  <= SEG_BLANK;
            seg_right <= SEG_BLANK;
        end else if (blank) begin
            seg_left  <= SEG_BLANK;
            seg_right <= SEG_BLANK;
        end else begin
            // A leading zero is displayed, never suppressed
            seg_left  <= digit_to_seg(4'(value / 7'd10));
            seg_right <= digit_to_seg(4'(value % 7'd10));
        end
    end

endmodule

// File: rtl/parking_controller_mf.sv
// Multi-floor parking access controller: keypad op/floor/PIN transactions, per-floor free counts.
// Latency: last PIN key edge k -> CHECK k+1 -> count/LED k+2 -> displays k+3.
// Backpressure: none; one-cycle CHECK/ACCEPT/REJECT states ignore keys, operator pacing covers it.
// Ports: clk, rst_n, power, disp_floor, key_code/key_on in; 7-seg pairs, free_vec, LEDs out.
module parking_controller_mf
    import parking_pkg::*;
#(
    parameter int          NUM_FLOORS     = 2,
    parameter int          FLOOR_CAP      = 15,
    parameter int          PIN_LEN        = 3,
    parameter logic [15:0] PIN            = 16'h0113,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          LED_HOLD       = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    power,
    input  logic [3:0]              disp_floor,
    input  logic [7:0]              key_code,
    input  logic                    key_on,
    output logic [6:0]              flr_bcd_left,
    output logic [6:0]              flr_bcd_right,
    output logic [6:0]              tot_bcd_left,
    output logic [6:0]              tot_bcd_right,
    output logic [NUM_FLOORS*7-1:0] free_vec,
    output logic                    red_power_led,
    output logic                    red_wrong_led,
    output logic                    green_led
);

    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int         HW       = $clog2(LED_HOLD + 1);
    localparam logic [1:0] PIN_LAST = 2'(PIN_LEN - 1);

    state_t         state, state_nxt;
    logic           key_prev;
    logic           key_evt;
    logic [4:0]     scan;
    logic           is_dig, is_esc;
    logic [3:0]     dig;
    logic           op_exit;
    logic [3:0]     flr;
    logic [1:0]     pin_idx;
    logic           pin_ok;
    logic [3:0]     exp_dig;
    logic [TW-1:0]  tmo_cnt;
    logic           tmo_hit;
    logic [HW-1:0]  hold_cnt;
    logic [6:0]     free_cnt [NUM_FLOORS];
    logic [6:0]     free_sel, disp_sel, total;
    logic           room_ok;
    logic           ld_op, ld_flr, ld_pin, do_accept, do_reject, tmo_run;

    // One event per rising edge of the held key level; ignored while powered off
    assign key_evt = power && key_on && !key_prev;
    assign scan    = scan_to_digit(key_code);
    assign is_dig  = scan[4];
    assign dig     = scan[3:0];
    assign is_esc  = (key_code == KEY_ESC);
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Mux selects written as loops so index widths never mismatch the array size
    always_comb begin
        free_sel = '0;
        disp_sel = '0;
        total    = '0;
        free_vec = '0;
        exp_dig  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (flr == 4'(i))        free_sel = free_cnt[i];
            if (disp_floor == 4'(i)) disp_sel = free_cnt[i];
            total = total + free_cnt[i];
            free_vec[i*7 +: 7] = free_cnt[i];
        end
        // PIN is compared digit by digit, most significant nibble first
        for (int i = 0; i < PIN_LEN; i++) begin
            if (pin_idx == 2'(i)) exp_dig = PIN[(PIN_LEN-1-i)*4 +: 4];
        end
    end

    assign room_ok = op_exit ? (free_sel != 7'(FLOOR_CAP)) : (free_sel != 7'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (!power) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:
                    if (key_evt && is_dig && (dig == 4'd1 || dig == 4'd2))
                        state_nxt = ST_GET_FLR;
                ST_GET_FLR:
                    if (key_evt) begin
                        if (is_esc)                             state_nxt = ST_IDLE;
                        else if (is_dig && int'(dig) < NUM_FLOORS) state_nxt = ST_GET_PIN;
                        else                                    state_nxt = ST_REJECT;
                    end else if (tmo_hit) begin
                        state_nxt = ST_REJECT;
                    end
                ST_GET_PIN:
                    if (key_evt) begin
                        if (is_esc)                     state_nxt = ST_IDLE;
                        else if (!is_dig)               state_nxt = ST_REJECT;
                        else if (pin_idx == PIN_LAST)   state_nxt = ST_CHECK;
                    end else if (tmo_hit) begin
                        state_nxt = ST_REJECT;
                    end
                ST_CHECK:
                    state_nxt = (pin_ok && (dig == dig) && room_ok) ? ST_ACCEPT : ST_REJECT;
                default:
                    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Control outputs of the FSM
    always_comb begin
        ld_op     = (state == ST_IDLE)    && (state_nxt == ST_GET_FLR);
        ld_flr    = (state == ST_GET_FLR) && (state_nxt == ST_GET_PIN);
        ld_pin    = (state == ST_GET_PIN) && key_evt && is_dig;
        do_accept = power && (state == ST_ACCEPT);
        do_reject = power && (state == ST_REJECT);
        tmo_run   = (state == ST_GET_FLR) || (state == ST_GET_PIN);
    end

    // Transaction datapath, counters and LEDs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev      <= 1'b0;
            op_exit       <= 1'b0;
            flr           <= '0;
            pin_idx       <= '0;
            pin_ok        <= 1'b0;
            tmo_cnt       <= '0;
            hold_cnt      <= '0;
            green_led     <= 1'b0;
            red_wrong_led <= 1'b0;
            red_power_led <= 1'b0;
            for (int i = 0; i < NUM_FLOORS; i++) free_cnt[i] <= 7'(FLOOR_CAP);
        end else begin
            key_prev      <= key_on;
            red_power_led <= !power;

            if (ld_op) op_exit <= (dig == 4'd2);
            // Entering GET_PIN always restarts PIN collection, so nothing stale survives
            if (ld_flr) begin
                flr     <= dig;
                pin_idx <= '0;
                pin_ok  <= 1'b1;
            end
            if (ld_pin) begin
                pin_idx <= pin_idx + 2'd1;
                pin_ok  <= pin_ok && (dig == exp_dig);
            end

            if (!tmo_run || key_evt) tmo_cnt <= '0;
            else if (!tmo_hit)       tmo_cnt <= tmo_cnt + 1'b1;

            // Guards in CHECK make wrap impossible here
            if (do_accept) begin
                for (int i = 0; i < NUM_FLOORS; i++) begin
                    if (flr == 4'(i))
                        free_cnt[i] <= op_exit ? free_cnt[i] + 7'd1 : free_cnt[i] - 7'd1;
                end
            end

            // A new result restarts the hold and overrides the other LED
            if (!power) begin
                green_led     <= 1'b0;
                red_wrong_led <= 1'b0;
                hold_cnt      <= '0;
            end else if (do_accept || do_reject) begin
                green_led     <= do_accept;
                red_wrong_led <= do_reject;
                hold_cnt      <= HW'(LED_HOLD - 1);
            end else if (green_led || red_wrong_led) begin
                if (hold_cnt == '0) begin
                    green_led     <= 1'b0;
                    red_wrong_led <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end
        end
    end

    bcd7seg_2dig u_flr_disp (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (disp_sel),
        .blank     (!power || int'(disp_floor) >= NUM_FLOORS),
        .seg_left  (flr_bcd_left),
        .seg_right (flr_bcd_right)
    );

    bcd7seg_2dig u_tot_disp (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (total),
        .blank     (!power),
        .seg_left  (tot_bcd_left),
        .seg_right (tot_bcd_right)
    );

endmodule

// File: tb/tb_parking_controller_mf.sv
// Directed bench for parking_controller_mf with default parameters (PIN digits 1,1,3).
// Latency: n/a.
// Backpressure: n/a.
module tb_parking_controller_mf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        power;
    logic [3:0]  disp_floor;
    logic [7:0]  key_code;
    logic        key_on;
    logic [6:0]  flr_bcd_left, flr_bcd_right, tot_bcd_left, tot_bcd_right;
    logic [13:0] free_vec;
    logic        red_power_led, red_wrong_led, green_led;

    int   checks    = 0;
    int   failures  = 0;
    int   green_cnt = 0;
    int   red_cnt   = 0;
    logic cnt_clr   = 1'b0;

    always #5 clk = ~clk;

    parking_controller_mf dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .power         (power),
        .disp_floor    (disp_floor),
        .key_code      (key_code),
        .key_on        (key_on),
        .flr_bcd_left  (flr_bcd_left),
        .flr_bcd_right (flr_bcd_right),
        .tot_bcd_left  (tot_bcd_left),
        .tot_bcd_right (tot_bcd_right),
        .free_vec      (free_vec),
        .red_power_led (red_power_led),
        .red_wrong_led (red_wrong_led),
        .green_led     (green_led)
    );

    // Counts how many cycles each result LED is lit
    always @(negedge clk) begin
        if (cnt_clr) begin
            green_cnt = 0;
            red_cnt   = 0;
        end else begin
            if (green_led)     green_cnt = green_cnt + 1;
            if (red_wrong_led) red_cnt   = red_cnt + 1;
        end
    end

    // 0..9 are digits, 10 is Esc
    function automatic logic [7:0] kc(input int d);
        case (d)
            0: kc = 8'h45;  1: kc = 8'h16;  2: kc = 8'h1E;  3: kc = 8'h26;
            4: kc = 8'h25;  5: kc = 8'h2E;  6: kc = 8'h36;  7: kc = 8'h3D;
            8: kc = 8'h3E;  9: kc = 8'h46;  default: kc = 8'h76;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: exp_seg = 7'h40;  1: exp_seg = 7'h79;  2: exp_seg = 7'h24;  3: exp_seg = 7'h30;
            4: exp_seg = 7'h19;  5: exp_seg = 7'h12;  6: exp_seg = 7'h02;  7: exp_seg = 7'h78;
            8: exp_seg = 7'h00;  9: exp_seg = 7'h10;  default: exp_seg = 7'h7F;
        endcase
    endfunction

    task automatic press(input int d);
        @(negedge clk);
        key_code = kc(d);
        key_on   = 1'b1;
        repeat (10) @(negedge clk);
        key_on = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; power = 1'b1; disp_floor = 4'd0; key_code = 8'h00; key_on = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (free_vec !== {7'd15, 7'd15}) begin failures++; $display("FAIL reset_free got=%h exp=%h", free_vec, {7'd15, 7'd15}); end
        checks++; if (tot_bcd_left !== 7'h7F || flr_bcd_right !== 7'h7F) begin failures++; $display("FAIL reset_blank got=%h/%h exp=7f", tot_bcd_left, flr_bcd_right); end
        checks++; if ({green_led, red_wrong_led, red_power_led} !== 3'b000) begin failures++; $display("FAIL reset_leds got=%b exp=000", {green_led, red_wrong_led, red_power_led}); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tot_bcd_left !== exp_seg(3) || tot_bcd_right !== exp_seg(0)) begin failures++; $display("FAIL reset_tot got=%h/%h exp=%h/%h", tot_bcd_left, tot_bcd_right, exp_seg(3), exp_seg(0)); end
        checks++; if (flr_bcd_left !== exp_seg(1) || flr_bcd_right !== exp_seg(5)) begin failures++; $display("FAIL reset_flr got=%h/%h exp=%h/%h", flr_bcd_left, flr_bcd_right, exp_seg(1), exp_seg(5)); end
    endtask

    task automatic test_enter();
        clr_cnt();
        press(1); press(0); press(1); press(1);
        // Final PIN key driven by hand to check the k+2 / k+3 latency
        @(negedge clk);
        key_code = kc(3);
        key_on   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (green_led !== 1'b0) begin failures++; $display("FAIL enter_early_green got=%b exp=0", green_led); end
        @(negedge clk);
        checks++; if (green_led !== 1'b1 || free_vec[6:0] !== 7'd14) begin failures++; $display("FAIL enter_k2 green=%b free0=%0d exp=1/14", green_led, free_vec[6:0]); end
        checks++; if (tot_bcd_right !== exp_seg(0)) begin failures++; $display("FAIL enter_disp_k2 got=%h exp=%h", tot_bcd_right, exp_seg(0)); end
        @(negedge clk);
        checks++; if (tot_bcd_left !== exp_seg(2) || tot_bcd_right !== exp_seg(9)) begin failures++; $display("FAIL enter_disp_k3 got=%h/%h exp=%h/%h", tot_bcd_left, tot_bcd_right, exp_seg(2), exp_seg(9)); end
        repeat (7) @(negedge clk);
        key_on = 1'b0;
        repeat (80) @(negedge clk);
        checks++; if (green_cnt !== 50 || red_cnt !== 0) begin failures++; $display("FAIL enter_led_cycles green=%0d red=%0d exp=50/0", green_cnt, red_cnt); end
        checks++; if (flr_bcd_left !== exp_seg(1) || flr_bcd_right !== exp_seg(4)) begin failures++; $display("FAIL enter_flr got=%h/%h exp=%h/%h", flr_bcd_left, flr_bcd_right, exp_seg(1), exp_seg(4)); end
    endtask

    task automatic test_wrong_pin();
        clr_cnt();
        press(1); press(1); press(0); press(1); press(2);
        repeat (80) @(negedge clk);
        checks++; if (red_cnt !== 50 || green_cnt !== 0) begin failures++; $display("FAIL wrong_pin_leds red=%0d green=%0d exp=50/0", red_cnt, green_cnt); end
        checks++; if (free_vec !== {7'd15, 7'd14}) begin failures++; $display("FAIL wrong_pin_counts got=%h exp=%h", free_vec, {7'd15, 7'd14}); end
        clr_cnt();
        press(1); press(5);
        repeat (80) @(negedge clk);
        checks++; if (red_cnt !== 50 || green_cnt !== 0) begin failures++; $display("FAIL bad_floor_leds red=%0d green=%0d exp=50/0", red_cnt, green_cnt); end
        disp_floor = 4'd1;
        repeat (2) @(negedge clk);
        checks++; if (flr_bcd_left !== exp_seg(1) || flr_bcd_right !== exp_seg(5)) begin failures++; $display("FAIL disp_floor1 got=%h/%h exp=%h/%h", flr_bcd_left, flr_bcd_right, exp_seg(1), exp_seg(5)); end
        disp_floor = 4'd3;
        repeat (2) @(negedge clk);
        checks++; if (flr_bcd_left !== 7'h7F || flr_bcd_right !== 7'h7F) begin failures++; $display("FAIL disp_floor_oob got=%h/%h exp=7f/7f", flr_bcd_left, flr_bcd_right); end
        disp_floor = 4'd0;
    endtask

    task automatic test_fill();
        for (int n = 0; n < 15; n++) begin
            press(1); press(1); press(1); press(1); press(3);
        end
        repeat (80) @(negedge clk);
        checks++; if (free_vec[13:7] !== 7'd0) begin failures++; $display("FAIL fill_count got=%0d exp=0", free_vec[13:7]); end
        clr_cnt();
        press(1); press(1); press(1); press(1); press(3);
        repeat (80) @(negedge clk);
        checks++; if (red_cnt !== 50 || green_cnt !== 0 || free_vec[13:7] !== 7'd0) begin failures++; $display("FAIL full_reject red=%0d green=%0d free1=%0d exp=50/0/0", red_cnt, green_cnt, free_vec[13:7]); end
        checks++; if (tot_bcd_left !== exp_seg(1) || tot_bcd_right !== exp_seg(4)) begin failures++; $display("FAIL full_tot got=%h/%h exp=%h/%h", tot_bcd_left, tot_bcd_right, exp_seg(1), exp_seg(4)); end
        clr_cnt();
        press(2); press(1); press(1); press(1); press(3);
        repeat (80) @(negedge clk);
        checks++; if (green_cnt !== 50 || free_vec[13:7] !== 7'd1) begin failures++; $display("FAIL exit_floor1 green=%0d free1=%0d exp=50/1", green_cnt, free_vec[13:7]); end
    endtask

    task automatic test_timeout();
        clr_cnt();
        press(1); press(0);
        repeat (880) @(negedge clk);
        checks++; if (red_cnt !== 0) begin failures++; $display("FAIL timeout_early red=%0d exp=0", red_cnt); end
        repeat (250) @(negedge clk);
        checks++; if (red_cnt !== 50 || green_cnt !== 0) begin failures++; $display("FAIL timeout_reject red=%0d green=%0d exp=50/0", red_cnt, green_cnt); end
        clr_cnt();
        press(1); press(0); press(10); press(3);
        repeat (80) @(negedge clk);
        checks++; if (red_cnt !== 0 || green_cnt !== 0) begin failures++; $display("FAIL esc_leds red=%0d green=%0d exp=0/0", red_cnt, green_cnt); end
        checks++; if (free_vec !== {7'd1, 7'd14}) begin failures++; $display("FAIL esc_counts got=%h exp=%h", free_vec, {7'd1, 7'd14}); end
    endtask

    task automatic test_power();
        clr_cnt();
        press(1); press(0); press(1); press(1);
        @(negedge clk);
        power = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tot_bcd_left !== 7'h7F || tot_bcd_right !== 7'h7F || flr_bcd_left !== 7'h7F) begin failures++; $display("FAIL power_blank got=%h/%h/%h exp=7f", tot_bcd_left, tot_bcd_right, flr_bcd_left); end
        checks++; if (red_power_led !== 1'b1 || green_led !== 1'b0 || red_wrong_led !== 1'b0) begin failures++; $display("FAIL power_leds got=%b%b%b exp=100", red_power_led, green_led, red_wrong_led); end
        power = 1'b1;
        repeat (3) @(negedge clk);
        // A stale GET_PIN state would take this 3 as the last correct PIN digit
        press(3);
        repeat (80) @(negedge clk);
        checks++; if (green_cnt !== 0 || red_cnt !== 0 || free_vec !== {7'd1, 7'd14}) begin failures++; $display("FAIL power_stale green=%0d red=%0d free=%h exp=0/0/%h", green_cnt, red_cnt, free_vec, {7'd1, 7'd14}); end
        checks++; if (red_power_led !== 1'b0) begin failures++; $display("FAIL power_restore got=%b exp=0", red_power_led); end
    endtask

    task automatic test_reset_mid();
        press(1); press(0); press(1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (free_vec !== {7'd15, 7'd15} || tot_bcd_left !== 7'h7F) begin failures++; $display("FAIL mid_reset got=%h/%h exp=%h/7f", free_vec, tot_bcd_left, {7'd15, 7'd15}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clr_cnt();
        // EXIT from a floor with no cars must be refused
        press(2); press(0); press(1); press(1); press(3);
        repeat (80) @(negedge clk);
        checks++; if (red_cnt !== 50 || green_cnt !== 0 || free_vec !== {7'd15, 7'd15}) begin failures++; $display("FAIL empty_exit red=%0d green=%0d free=%h exp=50/0/%h", red_cnt, green_cnt, free_vec, {7'd15, 7'd15}); end
    endtask

    initial begin
        test_reset();
        test_enter();
        test_wrong_pin();
        test_fill();
        test_timeout();
        test_power();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
